// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC Avalon-ST packetizer.
package adc_pkt_pkg;
    localparam int WORDS_PER_BEAT = 16;
    localparam int BEAT_W         = 512;
    localparam int EMPTY_W        = 6;

    typedef enum logic [1:0] {IDLE, ARMED, ACQ, DRAIN} acq_state_t;

    typedef struct packed {
        logic [BEAT_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    // Unused bytes of a beat holding k (1..15) words.
    function automatic logic [EMPTY_W-1:0] pad_empty(input logic [3:0] k);
        logic [EMPTY_W:0] v;
        v = 7'd64 - {1'b0, k, 2'b00};
        return v[EMPTY_W-1:0];
    endfunction
endpackage

// File: rtl/adc_st_out_stage.sv
// Tail beat register plus registered Avalon-ST output with valid/ready handshake.
module adc_st_out_stage
    import adc_pkt_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_load,
    input  beat_t i_load_beat,
    input  logic  i_set_eop,
    input  logic  i_release,
    input  logic  i_st_ready,
    output logic  o_tail_valid,
    output logic  o_tail_free,
    output logic  o_out_valid,
    output beat_t o_out_beat,
    output logic  o_eop_accept
);
    logic  r_tail_v;
    logic  r_out_v;
    beat_t r_tail;
    beat_t r_out;
    logic  w_move;

    // A non-eop tail beat is held back until the next beat has started, so an
    // abort can still mark it as the end of the packet.
    assign w_move = r_tail_v && (r_tail.eop || i_release) && (!r_out_v || i_st_ready);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tail_v <= 1'b0;
            r_tail   <= '0;
            r_out_v  <= 1'b0;
            r_out    <= '0;
        end else begin
            if (w_move) begin
                r_out   <= r_tail;
                r_out_v <= 1'b1;
            end else if (i_st_ready) begin
                r_out_v <= 1'b0;
            end
            if (i_load) begin
                r_tail   <= i_load_beat;
                r_tail_v <= 1'b1;
            end else if (w_move) begin
                r_tail_v <= 1'b0;
            end else if (i_set_eop) begin
                r_tail.eop   <= 1'b1;
                r_tail.empty <= '0;
            end
        end
    end

    assign o_tail_valid = r_tail_v;
    assign o_tail_free  = !r_tail_v || w_move;
    assign o_out_valid  = r_out_v;
    assign o_out_beat   = r_out;
    assign o_eop_accept = r_out_v && i_st_ready && r_out.eop;
endmodule

// File: rtl/adc_st_packetizer.sv
// Acquisition FSM, 32-bit word packer and packet framing for the 512-bit ADC ST sink.
module adc_st_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int NBEATS_W = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_arm,
    input  logic                i_cont,
    input  logic                i_sw_trig,
    input  logic                i_ext_trig,
    input  logic                i_abort,
    input  logic [NBEATS_W-1:0] i_nbeats,
    input  logic [WORD_W-1:0]   i_smp_data,
    input  logic                i_smp_valid,
    output logic [BEAT_W-1:0]   o_st_data,
    output logic                o_st_valid,
    input  logic                i_st_ready,
    output logic                o_st_sop,
    output logic                o_st_eop,
    output logic [EMPTY_W-1:0]  o_st_empty,
    output logic                o_busy,
    output logic                o_overflow,
    output logic [15:0]         o_pkt_count
);
    acq_state_t r_state;
    acq_state_t w_state_nx;
    logic [WORD_W*(WORDS_PER_BEAT-1)-1:0] r_pack;
    logic [3:0]          r_cnt;
    logic [NBEATS_W-1:0] r_beat;
    logic [NBEATS_W-1:0] r_last_idx;
    logic                r_ext_q;
    logic                r_pad_pend;
    logic                r_overflow;
    logic [15:0]         r_pkt_count;

    logic w_trig, w_word, w_full, w_abort_acq, w_form_full, w_form_pad;
    logic w_ovf, w_set_eop, w_is_last, w_start;
    logic w_tail_valid, w_tail_free, w_out_valid, w_eop_accept;
    logic [BEAT_W-1:0] w_pad_data;
    beat_t w_load_beat;
    beat_t w_out_beat;

    assign w_trig      = i_sw_trig || (i_ext_trig && !r_ext_q);
    assign w_start     = (r_state == ARMED) && !i_abort && w_trig;
    assign w_word      = (r_state == ACQ) && i_smp_valid && !i_abort;
    assign w_full      = w_word && (r_cnt == 4'd15);
    assign w_abort_acq = (r_state == ACQ) && i_abort;
    assign w_form_full = w_full && w_tail_free;
    assign w_ovf       = w_full && !w_tail_free;
    assign w_form_pad  = (w_abort_acq || r_pad_pend) && (r_cnt != 4'd0) && w_tail_free;
    assign w_set_eop   = w_abort_acq && (r_cnt == 4'd0) && w_tail_valid;
    assign w_is_last   = (r_beat == r_last_idx);

    // Newest word sits at the LSB end of r_pack; shifting by 32*(15-k) puts the
    // oldest word at the beat MSBs and zero-fills the rest.
    assign w_pad_data = {r_pack, {WORD_W{1'b0}}} << {~r_cnt, 5'b00000};

    always_comb begin
        w_load_beat.data  = w_form_pad ? w_pad_data : {r_pack, i_smp_data};
        w_load_beat.sop   = (r_beat == '0);
        w_load_beat.eop   = w_form_pad || w_is_last;
        w_load_beat.empty = w_form_pad ? pad_empty(r_cnt) : '0;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:  if (i_arm) w_state_nx = ARMED;
            ARMED: begin
                if (i_abort)     w_state_nx = IDLE;
                else if (w_trig) w_state_nx = ACQ;
            end
            ACQ: begin
                if (i_abort)
                    w_state_nx = (r_cnt == 4'd0 && !w_tail_valid) ? IDLE : DRAIN;
                else if (w_form_full && w_is_last)
                    w_state_nx = DRAIN;
            end
            DRAIN: begin
                if (!r_pad_pend && !w_tail_valid && !w_out_valid)
                    w_state_nx = i_cont ? ARMED : IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_pack      <= '0;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_last_idx  <= '0;
            r_ext_q     <= 1'b0;
            r_pad_pend  <= 1'b0;
            r_overflow  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ext_q <= i_ext_trig;
            if (w_start) begin
                r_beat     <= '0;
                r_last_idx <= (i_nbeats == '0) ? '0 : i_nbeats - NBEATS_W'(1);
            end else if (w_form_full) begin
                r_beat <= r_beat + NBEATS_W'(1);
            end
            if (w_form_full || w_form_pad) begin
                r_cnt <= '0;
            end else if (w_word && !w_full) begin
                r_pack <= {r_pack[WORD_W*(WORDS_PER_BEAT-2)-1:0], i_smp_data};
                r_cnt  <= r_cnt + 4'd1;
            end
            if (w_form_pad)
                r_pad_pend <= 1'b0;
            else if (w_abort_acq && r_cnt != 4'd0)
                r_pad_pend <= 1'b1;
            if (r_state == IDLE && i_arm)
                r_overflow <= 1'b0;
            else if (w_ovf)
                r_overflow <= 1'b1;
            if (w_eop_accept)
                r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    adc_st_out_stage u_out (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (w_form_full || w_form_pad),
        .i_load_beat  (w_load_beat),
        .i_set_eop    (w_set_eop),
        .i_release    (r_cnt != 4'd0),
        .i_st_ready   (i_st_ready),
        .o_tail_valid (w_tail_valid),
        .o_tail_free  (w_tail_free),
        .o_out_valid  (w_out_valid),
        .o_out_beat   (w_out_beat),
        .o_eop_accept (w_eop_accept)
    );

    assign o_st_data   = w_out_beat.data;
    assign o_st_sop    = w_out_beat.sop;
    assign o_st_eop    = w_out_beat.eop;
    assign o_st_empty  = w_out_beat.empty;
    assign o_st_valid  = w_out_valid;
    assign o_busy      = (r_state != IDLE) || w_tail_valid || w_out_valid;
    assign o_overflow  = r_overflow;
    assign o_pkt_count = r_pkt_count;
endmodule

// File: tb/tb_adc_st_packetizer.sv
// Directed and randomized bench for adc_st_packetizer against a word-list packet model.
module tb_adc_st_packetizer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         arm = 0, cont = 0, sw_trig = 0, ext_trig = 0, abort = 0;
    logic [15:0]  nbeats = 16'd1;
    logic [31:0]  smp_data = '0;
    logic         smp_valid = 0;
    logic         st_ready = 1'b1;
    logic [511:0] st_data;
    logic         st_valid, st_sop, st_eop, busy, overflow;
    logic [5:0]   st_empty;
    logic [15:0]  pkt_count;

    always #5 clk = ~clk;

    adc_st_packetizer dut (
        .i_clk(clk), .i_reset(reset), .i_arm(arm), .i_cont(cont),
        .i_sw_trig(sw_trig), .i_ext_trig(ext_trig), .i_abort(abort),
        .i_nbeats(nbeats), .i_smp_data(smp_data), .i_smp_valid(smp_valid),
        .o_st_data(st_data), .o_st_valid(st_valid), .i_st_ready(st_ready),
        .o_st_sop(st_sop), .o_st_eop(st_eop), .o_st_empty(st_empty),
        .o_busy(busy), .o_overflow(overflow), .o_pkt_count(pkt_count)
    );

    typedef struct {
        logic [511:0] d;
        logic         sop;
        logic         eop;
        logic [5:0]   e;
    } obs_t;

    obs_t        got_q[$];
    logic [31:0] exp_q[$];
    int          n_chk = 0, n_pass = 0, stab_err = 0;
    int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic        prev_stall = 1'b0;
    obs_t        prev;

    initial forever begin
        @(posedge clk); #1;
        if (ready_mode == 2) st_ready = ($urandom_range(0, 3) != 0);
        else                 st_ready = (ready_mode == 1);
    end

    // Collects accepted beats and flags any change of a stalled beat.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (st_valid !== 1'b1 || st_data !== prev.d || st_sop !== prev.sop ||
                               st_eop !== prev.eop || st_empty !== prev.e))
                stab_err++;
            if (st_valid && st_ready) got_q.push_back('{st_data, st_sop, st_eop, st_empty});
            prev_stall = st_valid && !st_ready;
            prev = '{st_data, st_sop, st_eop, st_empty};
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start(input int nb);
        nbeats = 16'(nb);
        arm = 1; step(); arm = 0;
        sw_trig = 1; step(); sw_trig = 0;
    endtask

    task automatic do_abort();
        abort = 1; step(); abort = 0;
    endtask

    task automatic feed_seq(input int first, input int n, input bit expect_it);
        for (int i = 0; i < n; i++) begin
            smp_valid = 1; smp_data = 32'(first + i);
            if (expect_it) exp_q.push_back(32'(first + i));
            step();
        end
        smp_valid = 0;
    endtask

    task automatic feed_rand(input int n);
        int sent = 0;
        while (sent < n) begin
            smp_valid = ($urandom_range(0, 3) != 0);
            smp_data  = $urandom;
            if (smp_valid) begin exp_q.push_back(smp_data); sent++; end
            step();
        end
        smp_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) step();
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_pkt(input string tag, input logic [15:0] target);
        for (int i = 0; i < 3000 && pkt_count !== target; i++) step();
        chk({tag, "_pkt"}, pkt_count, target);
    endtask

    // Expected packet: words in order, 16 per beat, first word in the MSBs,
    // a short final beat zero-padded with its unused bytes in empty.
    task automatic check_stream(input string tag);
        int nb, r;
        logic [511:0] d;
        logic [31:0]  w;
        nb = (exp_q.size() + 15) / 16;
        chk({tag, "_nbeats"}, got_q.size(), nb);
        for (int b = 0; b < nb && b < got_q.size(); b++) begin
            d = '0;
            for (int i = 0; i < 16; i++) begin
                w = (16 * b + i < exp_q.size()) ? exp_q[16 * b + i] : 32'h0;
                d = {d[479:0], w};
            end
            r = exp_q.size() - 16 * b;
            chk({tag, "_data"}, got_q[b].d, d);
            chk({tag, "_flags"}, {got_q[b].sop, got_q[b].eop, got_q[b].e},
                {(b == 0), (b == nb - 1), (r >= 16) ? 6'd0 : 6'(4 * (16 - r))});
        end
    endtask

    task automatic clear_model();
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        logic [15:0] pc0;
        int nb;

        repeat (3) step();
        reset = 0;
        step();
        chk("rst_valid", st_valid, 1'b0);
        chk("rst_flags", {st_sop, st_eop, st_empty}, 8'h0);
        chk("rst_data", st_data, 512'h0);
        chk("rst_status", {overflow, busy, pkt_count}, 18'h0);

        // two-beat packet, contiguous words, sink always ready
        clear_model();
        start(2);
        feed_seq(0, 32, 1);
        chk("t1_tail_latency", st_valid, 1'b0);
        step();
        chk("t1_last_valid", {st_valid, st_eop}, 2'b11);
        wait_idle("t1");
        check_stream("t1");
        chk("t1_word0_msb", got_q.size() > 0 ? got_q[0].d[511:480] : 32'hdead, 32'h0);
        chk("t1_pkt_count", pkt_count, 16'd1);

        // stalled sink: third beat overflows, word 47 is lost
        clear_model();
        ready_mode = 0;
        start(4);
        feed_seq(0, 47, 1);
        feed_seq(47, 1, 0);
        chk("t2_overflow", overflow, 1'b1);
        chk("t2_held_beat", {st_valid, st_sop, st_eop}, 3'b110);
        chk("t2_no_accept", got_q.size(), 0);
        ready_mode = 1;
        step(); step();
        feed_seq(48, 17, 1);
        wait_idle("t2");
        check_stream("t2");
        chk("t2_pkt_count", pkt_count, 16'd2);
        chk("t2_ovf_sticky", overflow, 1'b1);
        arm = 1; step(); arm = 0;
        chk("t2_arm_clears_ovf", overflow, 1'b0);
        do_abort();
        wait_idle("t2_abort_armed");
        chk("t2_abort_armed_no_beat", got_q.size(), 4);

        // abort after 5 words of beat 0
        clear_model();
        start(4);
        feed_seq(100, 5, 1);
        do_abort();
        wait_idle("t3");
        check_stream("t3");
        chk("t3_pkt_count", pkt_count, 16'd3);

        // abort exactly on a beat boundary: eop applied to the held tail beat
        clear_model();
        start(4);
        feed_seq(500, 16, 1);
        do_abort();
        wait_idle("t4");
        check_stream("t4");
        chk("t4_pkt_count", pkt_count, 16'd4);

        // continuous mode with ext_trig rising edges
        clear_model();
        pc0 = pkt_count;
        cont = 1; nbeats = 16'd1;
        arm = 1; step(); arm = 0;
        ext_trig = 1; step();
        feed_seq(200, 16, 1);
        wait_pkt("t5a", pc0 + 16'd1);
        check_stream("t5a");
        clear_model();
        feed_seq(300, 16, 0);
        repeat (5) step();
        chk("t5_held_no_retrig", got_q.size(), 0);
        chk("t5_held_pkt", pkt_count, pc0 + 16'd1);
        ext_trig = 0; step();
        ext_trig = 1; step();
        feed_seq(400, 16, 1);
        wait_pkt("t5b", pc0 + 16'd2);
        check_stream("t5b");
        repeat (4) step();
        cont = 0; ext_trig = 0;
        do_abort();
        wait_idle("t5");

        // reset with a stalled beat on the bus and overflow set
        clear_model();
        ready_mode = 0;
        start(4);
        feed_seq(0, 48, 0);
        chk("t6_pre_state", {st_valid, overflow}, 2'b11);
        reset = 1; step(); reset = 0;
        chk("t6_post_valid", st_valid, 1'b0);
        chk("t6_post_status", {busy, overflow, pkt_count}, 18'h0);
        ready_mode = 1;
        repeat (4) step();
        chk("t6_no_stale_beat", {st_valid, busy}, 2'b00);

        // randomized packets with gaps and random backpressure
        ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            clear_model();
            pc0 = pkt_count;
            nb = $urandom_range(0, 3);
            start(nb);
            feed_rand(16 * ((nb == 0) ? 1 : nb));
            wait_idle("rnd");
            check_stream("rnd");
            chk("rnd_pkt_count", pkt_count, pc0 + 16'd1);
            chk("rnd_no_overflow", overflow, 1'b0);
        end
        ready_mode = 1;

        chk("hold_stable", stab_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
